// File: rtl/brz_pkg.sv
// Shared types and defaults for the clocked Balsa-style variable.
package brz_pkg;

  localparam int unsigned BRZ_DEFAULT_WIDTH = 18;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_ACK  = 1'b1
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_ACK  = 1'b1
  } r_state_t;

endpackage

// File: rtl/brz_rd_port.sv
// One 4-phase pull read port: acknowledges a request only while grant_i is high,
// then holds the acknowledge until the request is withdrawn.
module brz_rd_port
  import brz_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic grant_i,
  output logic ack_o,
  output logic busy_o
);

  r_state_t state_q, state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      R_IDLE: if (req_i && grant_i) state_d = R_ACK;
      R_ACK:  if (!req_i)           state_d = R_IDLE;
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= R_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign ack_o  = (state_q == R_ACK);
  assign busy_o = (state_q == R_ACK);

endmodule

// File: rtl/brz_variable_clk.sv
// Clocked Balsa-style variable: one 4-phase push write port, READS pull read ports.
// Define BRZ_VARIABLE_VALID_EN to stall reads until the first write has completed.
module brz_variable_clk
  import brz_pkg::*;
#(
  parameter int unsigned     WIDTH     = BRZ_DEFAULT_WIDTH,
  parameter int unsigned     READS     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   write_0r,
  output logic                   write_0a,
  input  logic [WIDTH-1:0]       write_0d,
  input  logic [READS-1:0]       read_r,
  output logic [READS-1:0]       read_a,
  output logic [READS*WIDTH-1:0] read_d
);

  w_state_t         w_state_q, w_state_d;
  logic [WIDTH-1:0] store_q, store_d;
  logic [READS-1:0] rd_busy;
  logic             any_busy;
  logic             capture;
  logic             rd_grant;

  assign any_busy = |rd_busy;

  // Store only moves while no reader holds an acknowledge, keeping read_d stable.
  assign capture = (w_state_q == W_IDLE) && write_0r && !any_busy;

`ifdef BRZ_VARIABLE_VALID_EN
  logic valid_q, valid_d;

  assign valid_d = valid_q | capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign rd_grant = valid_q && (w_state_q == W_IDLE) && !capture;
`else
  assign rd_grant = (w_state_q == W_IDLE) && !capture;
`endif

  always_comb begin
    w_state_d = w_state_q;
    store_d   = store_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (capture) begin
          store_d   = write_0d;
          w_state_d = W_ACK;
        end
      end
      W_ACK: if (!write_0r) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      store_q   <= RESET_VAL;
    end else begin
      w_state_q <= w_state_d;
      store_q   <= store_d;
    end
  end

  assign write_0a = (w_state_q == W_ACK);

  for (genvar k = 0; k < READS; k++) begin : g_rd
    brz_rd_port u_rd_port (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_i   (read_r[k]),
      .grant_i (rd_grant),
      .ack_o   (read_a[k]),
      .busy_o  (rd_busy[k])
    );
    assign read_d[k*WIDTH +: WIDTH] = store_q;
  end

endmodule

// File: doc/brz_variable_clk.md
Name: brz_variable_clk

Overview:
- Clocked Balsa-style Variable: a storage register with one 4-phase push write port and READS 4-phase pull read ports.
- Sits directly upstream of the 16-of-18 slice stage; the slice's pull input connects to one of this block's read ports.
- The read port data is held stable for the whole read handshake, so the slice may sample at any point.

Parameters:
- WIDTH, 18, width of the stored word and of every data bus.
- READS, 1, number of independent pull read ports (1..4).
- RESET_VAL, 0, value loaded into the storage register at reset.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- write_0r  input  1  write request; data qualified while high.
- write_0a  output  1  write acknowledge.
- write_0d  input  WIDTH  write data.
- read_r  input  READS  per-port read requests.
- read_a  output  READS  per-port read acknowledges.
- read_d  output  READS*WIDTH  per-port read data; port k occupies bits [k*WIDTH +: WIDTH].

Behaviour:
- All handshake inputs are synchronous to clk; no synchronisers are included.
- Reset (rst_n low, asynchronous): store=RESET_VAL, write_0a=0, read_a=0. read_d shows the store value.
- Write FSM states: W_IDLE, W_ACK.
- In W_IDLE, when write_0r=1 and no read port is in R_ACK: on the next edge, store<=write_0d, write_0a<=1, go to W_ACK. Latency is 1 cycle from request to acknowledge.
- In W_ACK, when write_0r=0: on the next edge, write_0a<=0, go to W_IDLE.
- Per read port k, FSM states: R_IDLE, R_ACK.
- In R_IDLE, when read_r[k]=1 and the write FSM is in W_IDLE and is not capturing this cycle: on the next edge, read_a[k]<=1, go to R_ACK.
- In R_ACK, when read_r[k]=0: on the next edge, read_a[k]<=0, go to R_IDLE.
- Data stability rule: store must not change while any read_a is high. A pending write stalls in W_IDLE until every read port is in R_IDLE.
- Simultaneous write_0r and read_r rising in the same cycle: the write wins. Reads are then granted only after write_0a has returned to 0, so readers see the new value.
- Reads on different ports are independent and may overlap freely.
- Held requests: a request held high after its acknowledge simply waits in the ACK state; there are no repeat captures.
- Protocol violation (request dropped before acknowledge): the request is ignored with no state change.
- Reset mid-handshake: all acknowledges drop immediately and store=RESET_VAL. Re-entry is in the IDLE states.

Optional Feature:
- Macro: BRZ_VARIABLE_VALID_EN.
- When defined: an internal valid flag, cleared at reset and set on the first write capture. A read request made while valid=0 is stalled (read_a held 0) until the first write completes, i.e. write_0a has risen then fallen. The port flag "valid" is not exported.
- When undefined: reads are granted from reset and return RESET_VAL.

Decomposition:
- Shared package brz_pkg holds:
  - enum typedefs w_state_t {W_IDLE, W_ACK} and r_state_t {R_IDLE, R_ACK};
  - localparam BRZ_DEFAULT_WIDTH=18.
- Natural sub-module: brz_rd_port, one 4-phase read-acknowledge FSM instantiated READS times via generate, with a grant input and a busy output.

Test Plan:
- Reset then read port 0 (feature off): read_r[0]=1 → read_a[0]=1 after 1 cycle with read_d=18'h00000; drop read_r → read_a=0 after 1 cycle.
- Write then read: write_0d=18'h2A5C3, full 4-phase cycle; then read → read_d=18'h2A5C3. The slice downstream sees bits [16:1]=16'h52E1.
- Write during active read: store=18'h00001 and read_a[0]=1; raise write_0r with 18'h3FFFF → write_0a stays 0 and read_d stays 18'h00001 until read_r falls; write_0a rises 1 cycle after read_a[0] falls.
- Simultaneous requests (READS=2): write_0r, read_r[0] and read_r[1] rise together with write data 18'h12345 → write acknowledged first; both reads acknowledged in the same cycle after write_0a falls, each returning 18'h12345.
- Mid-handshake reset: assert rst_n=0 while write_0a=1 → write_0a and read_a drop asynchronously and store=RESET_VAL; after release a fresh write completes normally.
- BRZ_VARIABLE_VALID_EN defined: read_r[0]=1 right after reset → read_a[0] held 0 for 20 cycles. Then write 18'h0BEEF → read_a[0] rises 1 cycle after write_0a falls, with read_d=18'h0BEEF.
